// File: rtl/icache_ifill_unit_if.sv
// ---------------------------------------------------------------------------
// icache_ifill_unit_if
//
// Purpose: groups the fill-request / fill-response port towards the
// instruction cache and the 64-bit read port towards memory for the
// icache_ifill_unit refill engine.
//
// Handshakes:
//   - ifill_req : a request transfers on the rising edge where
//     ifill_req_valid_i && ifill_req_ready_o; the unit only raises ready
//     while idle.
//   - mem_req   : once mem_req_valid_o rises it stays high, with a stable
//     mem_req_addr_o, until the edge where mem_req_ready_i is also high.
//   - mem_resp  : no backpressure; every cycle with mem_resp_valid_i high
//     delivers one 64-bit word, in ascending address order.
//   - ifill_resp: no backpressure; ifill_resp_valid_o is a one-cycle pulse
//     per 128-bit beat, ifill_resp_ack_o marks the last beat of the line.
//
// Modports:
//   slave  : the refill unit's view (inputs from cache and memory).
//   master : the environment's view (cache + memory side).
// ---------------------------------------------------------------------------
interface icache_ifill_unit_if #(
    parameter int LINE_ADDR_W = 26,
    parameter int MEM_ADDR_W  = 32,
    parameter int MEM_DATA_W  = 64
);
    // Cache-side refill request
    logic                      ifill_req_valid_i;
    logic                      ifill_req_ready_o;
    logic [1:0]                ifill_req_way_i;
    logic [LINE_ADDR_W-1:0]    ifill_req_paddr_i;
    logic                      ifill_kill_i;

    // Cache-side refill response
    logic                      ifill_resp_valid_o;
    logic                      ifill_resp_ack_o;
    logic [1:0]                ifill_resp_beat_o;
    logic [1:0]                ifill_resp_way_o;
    logic [2*MEM_DATA_W-1:0]   ifill_resp_data_o;

    // Memory read port
    logic                      mem_req_valid_o;
    logic                      mem_req_ready_i;
    logic [MEM_ADDR_W-1:0]     mem_req_addr_o;
    logic                      mem_resp_valid_i;
    logic [MEM_DATA_W-1:0]     mem_resp_data_i;

    modport slave (
        input  ifill_req_valid_i,
        output ifill_req_ready_o,
        input  ifill_req_way_i,
        input  ifill_req_paddr_i,
        input  ifill_kill_i,
        output ifill_resp_valid_o,
        output ifill_resp_ack_o,
        output ifill_resp_beat_o,
        output ifill_resp_way_o,
        output ifill_resp_data_o,
        output mem_req_valid_o,
        input  mem_req_ready_i,
        output mem_req_addr_o,
        input  mem_resp_valid_i,
        input  mem_resp_data_i
    );

    modport master (
        output ifill_req_valid_i,
        input  ifill_req_ready_o,
        output ifill_req_way_i,
        output ifill_req_paddr_i,
        output ifill_kill_i,
        input  ifill_resp_valid_o,
        input  ifill_resp_ack_o,
        input  ifill_resp_beat_o,
        input  ifill_resp_way_o,
        input  ifill_resp_data_o,
        input  mem_req_valid_o,
        output mem_req_ready_i,
        input  mem_req_addr_o,
        output mem_resp_valid_i,
        output mem_resp_data_i
    );
endinterface

// File: rtl/icache_ifill_unit.sv
// ---------------------------------------------------------------------------
// icache_ifill_unit
//
// Purpose: instruction-cache line refill engine. Accepts one refill request
// (physical line address + victim way), issues a single memory read for the
// 64-byte line, pairs the eight 64-bit response words into four 128-bit
// beats and returns them to the cache with beat index, way and a completion
// acknowledge on the last beat. A kill from fetch suppresses the remaining
// response beats while the memory transaction still drains to completion.
//
// Ports:
//   clk_i          clock, rising edge
//   rstn_i         asynchronous active-low reset
//   bus            icache_ifill_unit_if.slave (cache request/response and
//                  memory read port; handshake rules in the interface file)
//   busy_o         high whenever a refill is in flight (miss-time counting)
//   dbg_state_o    current FSM state, for checkers
//   dbg_word_cnt_o current response-word counter, for checkers
//
// MEM_ADDR_W must equal LINE_ADDR_W + 6 and MEM_DATA_W must be 64.
// ---------------------------------------------------------------------------
module icache_ifill_unit #(
    parameter int LINE_ADDR_W = 26,
    parameter int MEM_ADDR_W  = 32,
    parameter int MEM_DATA_W  = 64
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    icache_ifill_unit_if.slave       bus,
    output logic                     busy_o,
    output logic [1:0]               dbg_state_o,
    output logic [2:0]               dbg_word_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                    state_q,      state_d;
    logic [LINE_ADDR_W-1:0]    paddr_q,      paddr_d;
    logic [1:0]                way_q,        way_d;
    logic [2:0]                cnt_q,        cnt_d;
    logic                      killed_q,     killed_d;
    logic [MEM_DATA_W-1:0]     lo_buf_q,     lo_buf_d;

    // Registered response beat
    logic                      resp_valid_q, resp_valid_d;
    logic                      resp_ack_q,   resp_ack_d;
    logic [1:0]                resp_beat_q,  resp_beat_d;
    logic [1:0]                resp_way_q,   resp_way_d;
    logic [2*MEM_DATA_W-1:0]   resp_data_q,  resp_data_d;

    // Kill seen this cycle or earlier in the current refill
    logic                      kill_now;
    logic [MEM_ADDR_W-1:0]     mem_addr;

    // ------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= IDLE;
            paddr_q      <= '0;
            way_q        <= '0;
            cnt_q        <= '0;
            killed_q     <= 1'b0;
            lo_buf_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_ack_q   <= 1'b0;
            resp_beat_q  <= '0;
            resp_way_q   <= '0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            paddr_q      <= paddr_d;
            way_q        <= way_d;
            cnt_q        <= cnt_d;
            killed_q     <= killed_d;
            lo_buf_q     <= lo_buf_d;
            resp_valid_q <= resp_valid_d;
            resp_ack_q   <= resp_ack_d;
            resp_beat_q  <= resp_beat_d;
            resp_way_q   <= resp_way_d;
            resp_data_q  <= resp_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        paddr_d      = paddr_q;
        way_d        = way_q;
        cnt_d        = cnt_q;
        killed_d     = killed_q;
        lo_buf_d     = lo_buf_q;
        // Valid/ack are single-cycle pulses; beat/way/data hold their
        // last value so they stay steady alongside and after the pulse.
        resp_valid_d = 1'b0;
        resp_ack_d   = 1'b0;
        resp_beat_d  = resp_beat_q;
        resp_way_d   = resp_way_q;
        resp_data_d  = resp_data_q;
        kill_now     = killed_q | bus.ifill_kill_i;

        unique case (state_q)
            IDLE: begin
                // A request that arrives together with a kill is already
                // stale from fetch's point of view, so it is not taken.
                if (bus.ifill_req_valid_i && !bus.ifill_kill_i) begin
                    paddr_d  = bus.ifill_req_paddr_i;
                    way_d    = bus.ifill_req_way_i;
                    killed_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = REQ;
                end
            end

            REQ: begin
                // The memory request is never withdrawn; a kill only
                // marks the refill so its response is dropped later.
                killed_d = kill_now;
                if (bus.mem_req_ready_i) begin
                    state_d = RESP;
                end
            end

            RESP: begin
                killed_d = kill_now;
                if (bus.mem_resp_valid_i) begin
                    cnt_d = cnt_q + 3'd1;
                    if (!cnt_q[0]) begin
                        lo_buf_d = bus.mem_resp_data_i;
                    end else if (!kill_now) begin
                        // Odd word completes a 128-bit beat; a kill in this
                        // very cycle already suppresses it.
                        resp_valid_d = 1'b1;
                        resp_ack_d   = (cnt_q == 3'd7);
                        resp_beat_d  = cnt_q[2:1];
                        resp_way_d   = way_q;
                        resp_data_d  = {bus.mem_resp_data_i, lo_buf_q};
                    end
                    // Word 7 closes the line whether killed or not; the
                    // counter wraps back to 0 on its own.
                    if (cnt_q == 3'd7) begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_addr               = {paddr_q, 6'b000000};

    assign bus.ifill_req_ready_o  = (state_q == IDLE);
    assign bus.mem_req_valid_o    = (state_q == REQ);
    assign bus.mem_req_addr_o     = mem_addr;

    assign bus.ifill_resp_valid_o = resp_valid_q;
    assign bus.ifill_resp_ack_o   = resp_ack_q;
    assign bus.ifill_resp_beat_o  = resp_beat_q;
    assign bus.ifill_resp_way_o   = resp_way_q;
    assign bus.ifill_resp_data_o  = resp_data_q;

    assign busy_o                 = (state_q != IDLE);
    assign dbg_state_o            = state_q;
    assign dbg_word_cnt_o         = cnt_q;

endmodule

// File: tb/tb_icache_ifill_unit.sv
// ---------------------------------------------------------------------------
// tb_icache_ifill_unit
//
// Bench for icache_ifill_unit. Driver tasks act as cache and memory; for
// every refill the expected beats (cycle, ack, way, beat, data) are derived
// from the line's eight words and pushed into exp_q; an independent monitor
// pops and compares whenever the unit pulses a response beat.
// ---------------------------------------------------------------------------
module tb_icache_ifill_unit;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // DUT
    // ------------------------------------------------------------------
    icache_ifill_unit_if bus ();
    logic       busy;
    logic [1:0] dbg_state;
    logic [2:0] dbg_cnt;

    icache_ifill_unit dut (
        .clk_i          (clk),
        .rstn_i         (rst_n),
        .bus            (bus),
        .busy_o         (busy),
        .dbg_state_o    (dbg_state),
        .dbg_word_cnt_o (dbg_cnt)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    // Entry: {expected cycle[32], ack, way[2], beat[2], data[128]}
    localparam int EW = 32 + 1 + 2 + 2 + 128;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every response pulse against the head of exp_q.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.ifill_resp_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {127'd0, bus.ifill_resp_valid_o}, 128'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("beat_cycle", {96'd0, cyc},                       {96'd0, mon_e[164:133]});
                    check("beat_ack",   {127'd0, bus.ifill_resp_ack_o},     {127'd0, mon_e[132]});
                    check("beat_way",   {126'd0, bus.ifill_resp_way_o},     {126'd0, mon_e[131:130]});
                    check("beat_index", {126'd0, bus.ifill_resp_beat_o},    {126'd0, mon_e[129:128]});
                    check("beat_data",  bus.ifill_resp_data_o,              mon_e[127:0]);
                end
            end else begin
                check("ack_without_valid", {127'd0, bus.ifill_resp_ack_o}, 128'd0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic drive_idle_inputs();
        bus.ifill_req_valid_i = 1'b0;
        bus.ifill_kill_i      = 1'b0;
        bus.mem_req_ready_i   = 1'b0;
        bus.mem_resp_valid_i  = 1'b0;
    endtask

    // Idle cycles with stray memory words and killed requests, neither of
    // which may disturb the unit.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.mem_resp_valid_i  = 1'($urandom_range(0, 1));
            bus.mem_resp_data_i   = {$urandom, $urandom};
            bus.ifill_req_valid_i = 1'($urandom_range(0, 1));
            bus.ifill_req_paddr_i = 26'($urandom);
            bus.ifill_kill_i      = bus.ifill_req_valid_i ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clk);
            check("idle_busy",  {127'd0, busy},                  128'd0);
            check("idle_ready", {127'd0, bus.ifill_req_ready_o}, 128'd1);
            check("idle_cnt",   {125'd0, dbg_cnt},               128'd0);
        end
        drive_idle_inputs();
    endtask

    // One complete refill, starting at a negedge with the unit idle and
    // ending at the negedge of the ack cycle. kill_word = 0..7 raises kill
    // together with that word; 8 means no kill in the response phase.
    // gap < 0 picks a random 0..2 idle cycles between words.
    task automatic refill(input logic [25:0] paddr, input logic [1:0] way, input int stall,
                          input int gap, input int kill_word, input bit kill_in_req,
                          input bit seq_words);
        logic [63:0] words [8];
        logic [31:0] exp_addr;
        bit          killed;
        int          g;

        exp_addr = {paddr, 6'b000000};
        for (int i = 0; i < 8; i++) words[i] = seq_words ? 64'(i) : {$urandom, $urandom};
        killed = kill_in_req;

        bus.ifill_req_valid_i = 1'b1;
        bus.ifill_req_paddr_i = paddr;
        bus.ifill_req_way_i   = way;
        bus.ifill_kill_i      = 1'b0;
        bus.mem_resp_valid_i  = 1'b0;
        @(negedge clk);
        bus.ifill_req_valid_i = 1'b0;
        check("accept_busy",       {127'd0, busy},                  128'd1);
        check("accept_ready_low",  {127'd0, bus.ifill_req_ready_o}, 128'd0);
        check("mem_req_valid",     {127'd0, bus.mem_req_valid_o},   128'd1);
        check("mem_req_addr",      {96'd0, bus.mem_req_addr_o},     {96'd0, exp_addr});

        // Request phase: optional backpressure, stray words and requests.
        for (int s = 0; s <= stall; s++) begin
            bus.mem_req_ready_i   = (s == stall);
            bus.ifill_kill_i      = kill_in_req && (s == 0);
            bus.mem_resp_valid_i  = 1'($urandom_range(0, 1));
            bus.mem_resp_data_i   = {$urandom, $urandom};
            bus.ifill_req_valid_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (s < stall) begin
                check("mem_req_valid_held", {127'd0, bus.mem_req_valid_o}, 128'd1);
                check("mem_req_addr_held",  {96'd0, bus.mem_req_addr_o},  {96'd0, exp_addr});
                check("req_cnt_zero",       {125'd0, dbg_cnt},            128'd0);
            end else begin
                check("mem_req_dropped",    {127'd0, bus.mem_req_valid_o}, 128'd0);
            end
        end
        bus.mem_req_ready_i = 1'b0;
        bus.ifill_kill_i    = 1'b0;

        // Response phase: word w pairs with word w-1 on odd w.
        for (int w = 0; w < 8; w++) begin
            if (w > 0) begin
                g = (gap >= 0) ? gap : $urandom_range(0, 2);
                for (int k = 0; k < g; k++) begin
                    bus.mem_resp_valid_i  = 1'b0;
                    bus.ifill_kill_i      = 1'b0;
                    bus.ifill_req_valid_i = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
            end
            bus.mem_resp_valid_i  = 1'b1;
            bus.mem_resp_data_i   = words[w];
            bus.ifill_kill_i      = (w == kill_word);
            bus.ifill_req_valid_i = 1'($urandom_range(0, 1));
            if (w == kill_word) killed = 1'b1;
            if ((w % 2 == 1) && !killed)
                exp_q.push_back({cyc + 32'd1, (w == 7), way, 2'(w / 2), words[w], words[w-1]});
            @(negedge clk);
        end
        check("done_ready", {127'd0, bus.ifill_req_ready_o}, 128'd1);
        check("done_busy",  {127'd0, busy},                  128'd0);
        drive_idle_inputs();
    endtask

    // Reset asserted in the middle of a response phase.
    task automatic mid_refill_reset();
        bus.ifill_req_valid_i = 1'b1;
        bus.ifill_req_paddr_i = 26'($urandom);
        bus.ifill_req_way_i   = 2'($urandom);
        @(negedge clk);
        bus.ifill_req_valid_i = 1'b0;
        bus.mem_req_ready_i   = 1'b1;
        @(negedge clk);
        bus.mem_req_ready_i   = 1'b0;
        bus.mem_resp_valid_i  = 1'b1;
        bus.mem_resp_data_i   = {$urandom, $urandom};
        @(negedge clk);
        bus.mem_resp_valid_i  = 1'b0;
        check("pre_reset_busy", {127'd0, busy}, 128'd1);
        check("pre_reset_cnt",  {125'd0, dbg_cnt}, 128'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_busy",  {127'd0, busy},                  128'd0);
        check("async_reset_ready", {127'd0, bus.ifill_req_ready_o}, 128'd1);
        check("async_reset_cnt",   {125'd0, dbg_cnt},               128'd0);
        check("async_reset_mreq",  {127'd0, bus.mem_req_valid_o},   128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        drive_idle_inputs();
        bus.ifill_req_way_i   = '0;
        bus.ifill_req_paddr_i = '0;
        bus.mem_resp_data_i   = '0;

        repeat (3) @(negedge clk);
        check("rst_ready",      {127'd0, bus.ifill_req_ready_o},  128'd1);
        check("rst_mem_valid",  {127'd0, bus.mem_req_valid_o},    128'd0);
        check("rst_mem_addr",   {96'd0, bus.mem_req_addr_o},      128'd0);
        check("rst_resp_valid", {127'd0, bus.ifill_resp_valid_o}, 128'd0);
        check("rst_resp_ack",   {127'd0, bus.ifill_resp_ack_o},   128'd0);
        check("rst_resp_beat",  {126'd0, bus.ifill_resp_beat_o},  128'd0);
        check("rst_resp_way",   {126'd0, bus.ifill_resp_way_o},   128'd0);
        check("rst_resp_data",  bus.ifill_resp_data_o,            128'd0);
        check("rst_busy",       {127'd0, busy},                   128'd0);
        check("rst_cnt",        {125'd0, dbg_cnt},                128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single refill with the reference line.
        refill(26'h0ABCDE, 2'd2, 0, 0, 8, 1'b0, 1'b1);
        idle(3);
        // Memory request backpressure.
        refill(26'($urandom), 2'($urandom), 5, 0, 8, 1'b0, 1'b0);
        idle(2);
        // Kill one cycle after beat 1 appears, then a normal refill.
        refill(26'($urandom), 2'($urandom), 0, 0, 5, 1'b0, 1'b0);
        idle(2);
        refill(26'($urandom), 2'($urandom), 0, 0, 8, 1'b0, 1'b0);
        idle(2);
        // Kill in the request phase while memory stalls.
        refill(26'($urandom), 2'($urandom), 4, 0, 8, 1'b1, 1'b0);
        // Stray words while idle, then gapped response words.
        idle(6);
        refill(26'($urandom), 2'($urandom), 1, 1, 8, 1'b0, 1'b0);
        idle(1);
        // Back-to-back: second request presented in the first's ack cycle.
        refill(26'($urandom), 2'($urandom), 0, 0, 8, 1'b0, 1'b0);
        refill(26'($urandom), 2'($urandom), 0, 0, 8, 1'b0, 1'b0);

        // Randomized refills.
        for (int r = 0; r < 24; r++) begin
            refill(26'($urandom), 2'($urandom), $urandom_range(0, 3),
                   ($urandom_range(0, 1) == 1) ? -1 : 0,
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : 8,
                   ($urandom_range(0, 7) == 0), 1'b0);
            idle($urandom_range(0, 2));
        end

        mid_refill_reset();
        refill(26'($urandom), 2'($urandom), 0, -1, 8, 1'b0, 1'b0);
        idle(4);

        check("all_beats_seen", 128'(exp_q.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Watchdog
    initial begin
        #500000;
        n_errors++;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
